// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared rounding, flag and operand-class definitions for the FP multiply stage
package fpu_pkg;

  localparam logic [2:0] RNE = 3'b000;
  localparam logic [2:0] RTZ = 3'b001;
  localparam logic [2:0] RDN = 3'b010;
  localparam logic [2:0] RUP = 3'b011;
  localparam logic [2:0] RMM = 3'b100;
  localparam logic [2:0] DYN = 3'b111;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [7:0]  EXP_ONES   = 8'hFF;
  localparam int          QUIET_BIT  = 22;
  localparam logic [31:0] CANON_QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
    logic snan;
  } op_class_t;

  typedef struct packed {
    logic [2:0] rm;
    logic       illegal;
  } rm_res_t;

  // DYN defers to the CSR; reserved encodings fall back to RNE and are flagged
  function automatic rm_res_t resolve_rm(input logic [2:0] rm, input logic [2:0] frm);
    rm_res_t    r;
    logic [2:0] eff;
    eff       = (rm == DYN) ? frm : rm;
    r.illegal = (eff == 3'b101) || (eff == 3'b110) || (eff == 3'b111);
    r.rm      = r.illegal ? RNE : eff;
    return r;
  endfunction

endpackage

// File: rtl/fp_mul.sv
// rtl/fp_mul.sv - combinational single-precision multiplier (subnormals flushed to zero)
module fp_mul
  import fpu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  R_M,
  output logic [31:0] result,
  output logic        OverFlow
);

  logic               sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic               guard, sticky, inc, max_finite;
  logic [47:0]        prod;
  logic [23:0]        mant;
  logic [24:0]        mant_r;
  logic signed [10:0] exp_n;

  // Multiply significands, normalise by at most one place, round, then resolve special operands
  always_comb begin
    sign       = a[31] ^ b[31];
    a_zero     = (a[30:23] == 8'h00);
    b_zero     = (b[30:23] == 8'h00);
    a_inf      = (a[30:23] == EXP_ONES) && (a[22:0] == 23'h0);
    b_inf      = (b[30:23] == EXP_ONES) && (b[22:0] == 23'h0);
    a_nan      = (a[30:23] == EXP_ONES) && (a[22:0] != 23'h0);
    b_nan      = (b[30:23] == EXP_ONES) && (b[22:0] != 23'h0);
    prod       = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
    exp_n      = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
    mant       = prod[46:23];
    guard      = prod[22];
    sticky     = |prod[21:0];
    if (prod[47]) begin
      mant   = prod[47:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      exp_n  = exp_n + 11'sd1;
    end
    case (R_M)
      RTZ:     inc = 1'b0;
      RDN:     inc = sign & (guard | sticky);
      RUP:     inc = ~sign & (guard | sticky);
      RMM:     inc = guard;
      default: inc = guard & (sticky | mant[0]);
    endcase
    mant_r = {1'b0, mant} + {24'h0, inc};
    // A rounding carry leaves the fraction all-zero, so mant_r[22:0] stays correct
    if (mant_r[24]) exp_n = exp_n + 11'sd1;
    max_finite = (R_M == RTZ) || ((R_M == RDN) && !sign) || ((R_M == RUP) && sign);
    OverFlow   = 1'b0;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      result = CANON_QNAN;
    end else if (a_inf || b_inf) begin
      result = {sign, EXP_ONES, 23'h0};
    end else if (a_zero || b_zero) begin
      result = {sign, 31'h0};
    end else if (exp_n >= 11'sd255) begin
      OverFlow = 1'b1;
      result   = max_finite ? {sign, 8'hFE, 23'h7F_FFFF} : {sign, EXP_ONES, 23'h0};
    end else if (exp_n <= 11'sd0) begin
      result = {sign, 31'h0};
    end else begin
      result = {sign, exp_n[7:0], mant_r[22:0]};
    end
  end

endmodule

// File: rtl/fpu_mul_pipe.sv
// rtl/fpu_mul_pipe.sv - two-stage issue/writeback wrapper around fp_mul with full backpressure
module fpu_mul_pipe
  import fpu_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [2:0]       in_rm,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [2:0]       frm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [4:0]       out_flags,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  logic             s1_v, s2_v, s2_adv, s1_move, accept;
  logic [31:0]      s1_a, s1_b, mul_result;
  logic [2:0]       s1_rm;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_ill, mul_of;
  logic [4:0]       flags_d;
  rm_res_t          rm_res;
  op_class_t        ca, cb;

  // Subnormals count as zero to match the datapath's flush-to-zero behaviour
  function automatic op_class_t classify(input logic [31:0] x);
    op_class_t c;
    logic      exp_ones, man_zero;
    exp_ones = (x[30:23] == EXP_ONES);
    man_zero = (x[22:0] == 23'h0);
    c.zero   = (x[30:23] == 8'h00);
    c.inf    = exp_ones && man_zero;
    c.nan    = exp_ones && !man_zero;
    c.snan   = c.nan && !x[QUIET_BIT];
    return c;
  endfunction

  assign s2_adv    = !s2_v || out_ready;
  assign s1_move   = s1_v && s2_adv;
  assign in_ready  = !s1_v || s2_adv;
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_v;
  assign rm_res    = resolve_rm(in_rm, frm);

  fp_mul u_fp_mul (
    .a        (s1_a),
    .b        (s1_b),
    .R_M      (s1_rm),
    .result   (mul_result),
    .OverFlow (mul_of)
  );

  // S1: capture operands and resolved rounding mode on every accepted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_rm  <= RNE;
      s1_tag <= '0;
      s1_ill <= 1'b0;
    end else begin
      if (flush)        s1_v <= 1'b0;
      else if (accept)  s1_v <= 1'b1;
      else if (s1_move) s1_v <= 1'b0;
      if (accept) begin
        s1_a   <= in_a;
        s1_b   <= in_b;
        s1_rm  <= rm_res.rm;
        s1_tag <= in_tag;
        s1_ill <= rm_res.illegal;
      end
    end
  end

  // Exception flags from the S1 operands; an illegal rm suppresses them all
  always_comb begin
    ca               = classify(s1_a);
    cb               = classify(s1_b);
    flags_d          = 5'h0;
    flags_d[FLAG_NV] = ca.snan || cb.snan || (ca.inf && cb.zero) || (ca.zero && cb.inf);
    flags_d[FLAG_DZ] = 1'b0;
    flags_d[FLAG_OF] = mul_of && !(ca.nan || ca.inf || cb.nan || cb.inf);
    flags_d[FLAG_UF] = 1'b0;
    flags_d[FLAG_NX] = 1'b0;
    if (s1_ill) flags_d = 5'h0;
  end

  // S2: result register, frozen while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v        <= 1'b0;
      out_result  <= 32'h0;
      out_flags   <= 5'h0;
      out_illegal <= 1'b0;
      out_tag     <= '0;
    end else begin
      if (flush)       s2_v <= 1'b0;
      else if (s2_adv) s2_v <= s1_v;
      if (s1_move) begin
        out_result  <= mul_result;
        out_flags   <= flags_d;
        out_illegal <= s1_ill;
        out_tag     <= s1_tag;
      end
    end
  end

endmodule
